// File: rtl/ir_frame_ctrl.sv
// ir_frame_ctrl: receives one IR controller frame from the demodulated pin.
//
// Sequence: leader mark, leader space, 16 data bits (mark + space, MSB first,
// long space = 1) and a stop mark. On completion the code is presented and
// latch pulses one cycle later. Malformed or timed-out frames pulse frame_err.
//
// Optional feature (macro IR_REPEAT_EN): a short leader space marks a repeat
// frame. After its single mark, latch pulses with code unchanged and
// repeat_flag high. Without the macro, repeat_flag is tied low.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   ir_rx_n     demodulated IR pin (low = mark, idle high), asynchronous
//   code        last valid received code, stable between frames
//   latch       one-cycle pulse, the cycle after code updates
//   frame_err   one-cycle pulse on abort (bad gap or timeout)
//   busy        high whenever the FSM is not idle
//   repeat_flag one-cycle pulse alongside latch for a repeat frame
module ir_frame_ctrl #(
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned LEADER_MIN = 9000,
  parameter int unsigned GAP_MIN    = 4000,
  parameter int unsigned BIT_THRESH = 1100,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_rx_n,
  output logic [15:0] code,
  output logic        latch,
  output logic        frame_err,
  output logic        busy,
  output logic        repeat_flag
);

  localparam logic [CNT_W-1:0] LeaderMin = CNT_W'(LEADER_MIN);
  localparam logic [CNT_W-1:0] GapMin    = CNT_W'(GAP_MIN);
  localparam logic [CNT_W-1:0] BitThresh = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] Timeout   = CNT_W'(TIMEOUT);
`ifdef IR_REPEAT_EN
  localparam logic [CNT_W-1:0] RptMin    = CNT_W'(GAP_MIN / 4);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StLeader,
    StGap,
    StMark,
    StSpace,
    StDone
`ifdef IR_REPEAT_EN
    , StRepeat
`endif
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, s_q, s_prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        idx_q, idx_d;
  logic [15:0]       shift_q, shift_d;
  logic [15:0]       code_q, code_d;
  logic              latch_q, latch_d;
  logic              err_q, err_d;
`ifdef IR_REPEAT_EN
  logic              rpt_q, rpt_d;
`endif

  logic fall, rise, any_edge, timed_out;

  assign fall      = s_prev_q & ~s_q;
  assign rise      = ~s_prev_q & s_q;
  assign any_edge  = fall | rise;
  // An edge in the same cycle as the timeout wins.
  assign timed_out = (cnt_q >= Timeout) && !any_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      s_q      <= 1'b1;
      s_prev_q <= 1'b1;
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      code_q   <= '0;
      latch_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= ir_rx_n;
      s_q      <= sync1_q;
      s_prev_q <= s_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      code_q   <= code_d;
      latch_q  <= latch_d;
      err_q    <= err_d;
    end
  end

`ifdef IR_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`endif

  // Level-duration counter: restarts at 1 on each edge, saturates at Timeout,
  // so cnt_q in an edge cycle is the length of the level just ended.
  always_comb begin
    cnt_d = cnt_q;
    if (any_edge) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q < Timeout) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    code_d  = code_q;
    latch_d = 1'b0;
    err_d   = 1'b0;
`ifdef IR_REPEAT_EN
    rpt_d   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (fall) state_d = StLeader;
      end
      StLeader: begin
        if (rise) begin
          // A short leader is treated as noise and dropped silently.
          state_d = (cnt_q >= LeaderMin) ? StGap : StIdle;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StGap: begin
        if (fall) begin
          if (cnt_q >= GapMin) begin
            state_d = StMark;
            idx_d   = '0;
            shift_d = '0;
`ifdef IR_REPEAT_EN
          end else if (cnt_q >= RptMin) begin
            state_d = StRepeat;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StMark: begin
        if (rise) begin
          if (idx_q < 5'd16) begin
            state_d = StSpace;
          end else begin
            // Stop mark ended: code is visible during StDone, latch follows.
            code_d  = shift_q;
            state_d = StDone;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StSpace: begin
        if (fall) begin
          shift_d = {shift_q[14:0], (cnt_q > BitThresh)};
          idx_d   = idx_q + 5'd1;
          state_d = StMark;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StDone: begin
        latch_d = 1'b1;
        // A leader may already start here when frames are back to back.
        state_d = fall ? StLeader : StIdle;
      end
`ifdef IR_REPEAT_EN
      StRepeat: begin
        if (rise) begin
          latch_d = 1'b1;
          rpt_d   = 1'b1;
          state_d = StIdle;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign code      = code_q;
  assign latch     = latch_q;
  assign frame_err = err_q;
  assign busy      = (state_q != StIdle);
`ifdef IR_REPEAT_EN
  assign repeat_flag = rpt_q;
`else
  assign repeat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ir_frame_ctrl.sv
module tb_ir_frame_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ir_rx_n;
  logic [15:0] code;
  logic        latch;
  logic        frame_err;
  logic        busy;
  logic        repeat_flag;

  int tests = 0;
  int fails = 0;

  // Event monitor state
  int          lat_cnt    = 0;
  int          err_cnt    = 0;
  int          rpt_cnt    = 0;
  int          rpt_alone  = 0;
  int          both_cnt   = 0;
  int          bad_timing = 0;
  logic [15:0] lat_codes[$];
  logic [15:0] c1 = 16'h0;
  logic [15:0] c2 = 16'h0;

  ir_frame_ctrl #(
    .CNT_W      (20),
    .LEADER_MIN (8),
    .GAP_MIN    (4),
    .BIT_THRESH (3),
    .TIMEOUT    (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ir_rx_n     (ir_rx_n),
    .code        (code),
    .latch       (latch),
    .frame_err   (frame_err),
    .busy        (busy),
    .repeat_flag (repeat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample 2 time units after each active edge.
  always @(posedge clk) begin
    #2;
    if (latch) begin
      lat_cnt++;
      lat_codes.push_back(code);
      // Code must already be new in the cycle before latch, and differ
      // from the value two cycles before (every data frame here changes it).
      if (!repeat_flag && !(c1 === code && c2 !== code)) bad_timing++;
    end
    if (frame_err) err_cnt++;
    if (repeat_flag) begin
      rpt_cnt++;
      if (!latch) rpt_alone++;
    end
    if (latch && frame_err) both_cnt++;
    c2 = c1;
    c1 = code;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Hold ir_rx_n at val for n cycles; always driven on the falling clock edge.
  task automatic level(input logic val, input int n);
    ir_rx_n = val;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] v, input int tail);
    level(1'b0, 10);
    level(1'b1, 6);
    for (int i = 15; i >= 0; i--) begin
      level(1'b0, 2);
      level(1'b1, v[i] ? 5 : 2);
    end
    level(1'b0, 2);
    level(1'b1, tail);
  endtask

  initial begin
    rst_n   = 1'b0;
    ir_rx_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_code", 32'(code), 32'h0);
    chk("reset_latch", 32'(latch), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rpt", 32'(repeat_flag), 32'h0);
    rst_n = 1'b1;
    level(1'b1, 5);

    // Valid frame
    send_frame(16'h0A0B, 10);
    chk("valid_code", 32'(code), 32'h0A0B);
    chk("valid_latch_cnt", 32'(lat_cnt), 32'd1);
    chk("valid_no_err", 32'(err_cnt), 32'd0);
    chk("valid_latch_timing", 32'(bad_timing), 32'd0);
    chk("valid_idle", 32'(busy), 32'h0);

    // Leader glitch
    level(1'b0, 5);
    chk("glitch_busy_mid", 32'(busy), 32'h1);
    level(1'b1, 10);
    chk("glitch_busy_end", 32'(busy), 32'h0);
    chk("glitch_latch_cnt", 32'(lat_cnt), 32'd1);
    chk("glitch_err_cnt", 32'(err_cnt), 32'd0);
    chk("glitch_code", 32'(code), 32'h0A0B);

    // Timeout: 3 bits, then a long space
    level(1'b0, 10);
    level(1'b1, 6);
    level(1'b0, 2);
    level(1'b1, 5);
    level(1'b0, 2);
    level(1'b1, 2);
    level(1'b0, 2);
    level(1'b1, 30);
    chk("tmo_not_yet", 32'(err_cnt), 32'd0);
    chk("tmo_busy_mid", 32'(busy), 32'h1);
    level(1'b1, 10);
    chk("tmo_err_once", 32'(err_cnt), 32'd1);
    chk("tmo_idle", 32'(busy), 32'h0);
    chk("tmo_code", 32'(code), 32'h0A0B);
    chk("tmo_latch_cnt", 32'(lat_cnt), 32'd1);

    // Reset mid-frame, during the 8th bit space
    level(1'b0, 10);
    level(1'b1, 6);
    for (int i = 0; i < 7; i++) begin
      level(1'b0, 2);
      level(1'b1, 5);
    end
    level(1'b0, 2);
    level(1'b1, 3);
    chk("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_code", 32'(code), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_latch", 32'(latch), 32'h0);
    chk("mid_rst_err", 32'(frame_err), 32'h0);
    chk("mid_rst_rpt", 32'(repeat_flag), 32'h0);
    @(negedge clk);
    level(1'b1, 3);
    rst_n = 1'b1;
    level(1'b1, 5);
    chk("mid_no_events", 32'(lat_cnt + err_cnt), 32'd2);
    send_frame(16'h0A12, 10);
    chk("mid_code", 32'(code), 32'h0A12);
    chk("mid_latch_cnt", 32'(lat_cnt), 32'd2);

    // Repeat frame
    send_frame(16'h0A04, 10);
    chk("rpt_base_code", 32'(code), 32'h0A04);
    level(1'b0, 10);
    level(1'b1, 2);
    level(1'b0, 2);
    level(1'b1, 10);
    chk("rpt_code", 32'(code), 32'h0A04);
`ifdef IR_REPEAT_EN
    chk("rpt_latch_cnt", 32'(lat_cnt), 32'd4);
    chk("rpt_flag_cnt", 32'(rpt_cnt), 32'd1);
    chk("rpt_err_cnt", 32'(err_cnt), 32'd1);
    chk("rpt_latch_code", 32'(lat_codes[3]), 32'h0A04);
`else
    chk("rpt_latch_cnt", 32'(lat_cnt), 32'd3);
    chk("rpt_flag_cnt", 32'(rpt_cnt), 32'd0);
    chk("rpt_err_cnt", 32'(err_cnt), 32'd2);
`endif

    // Back-to-back frames
    tests++;
    begin
      int base;
      base = lat_cnt;
      tests--;
      send_frame(16'h0A06, 1);
      send_frame(16'h0A08, 10);
      chk("b2b_latch_cnt", 32'(lat_cnt - base), 32'd2);
      if (lat_codes.size() >= base + 2) begin
        chk("b2b_code0", 32'(lat_codes[base]), 32'h0A06);
        chk("b2b_code1", 32'(lat_codes[base + 1]), 32'h0A08);
      end else begin
        chk("b2b_codes_present", 32'(lat_codes.size()), 32'(base + 2));
      end
    end
    chk("b2b_code", 32'(code), 32'h0A08);

    // Global invariants
    chk("latch_timing", 32'(bad_timing), 32'd0);
    chk("latch_err_overlap", 32'(both_cnt), 32'd0);
    chk("rpt_without_latch", 32'(rpt_alone), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ir_frame_ctrl.md
Name: ir_frame_ctrl

Overview:
- Sequences reception of one IR controller frame from the demodulated receiver pin (ir_rx_n).
- Measures mark/space widths, shifts in a 16-bit code MSB first, then presents it on code with a single-cycle latch strobe.
- code and latch drive the downstream button decoder's 16-bit input and latch input. Also flags malformed or timed-out frames.

Parameters:
- CNT_W, 20, width of the level-duration counter.
- LEADER_MIN, 9000, minimum leader mark length in clk cycles.
- GAP_MIN, 4000, minimum leader space length in clk cycles.
- BIT_THRESH, 1100, space length strictly greater than this decodes as 1, otherwise 0.
- TIMEOUT, 20000, maximum length of any single level inside a frame; must be below 2^CNT_W.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ir_rx_n  input  1  demodulated IR pin: low = mark, idle high; asynchronous.
- code  output  16  last valid received code; stable between frames.
- latch  output  1  one-cycle pulse, asserted the cycle after code updates.
- frame_err  output  1  one-cycle pulse on abort.
- busy  output  1  high in any state other than IDLE.
- repeat_flag  output  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset values: code=16'h0000, latch=0, frame_err=0, busy=0, repeat_flag=0, FSM=IDLE, counter=0, sync flops=1.
- Input path:
  - 2-flop synchronizer on ir_rx_n; all logic uses the synced level s.
  - Edge detect against the previous s.
  - Total input-to-edge latency is 3 cycles.
- Counter cnt:
  - Cleared to 1 on every synced edge.
  - Increments each cycle otherwise; saturates at TIMEOUT.
  - The length L of a level is the cnt value in the cycle its terminating edge is detected.
- FSM states: IDLE, LEADER, GAP, MARK, SPACE, DONE.
  - IDLE: falling edge -> LEADER.
  - LEADER (low): rising edge with L>=LEADER_MIN -> GAP. Rising edge with L<LEADER_MIN -> IDLE silently (glitch reject, no frame_err).
  - GAP (high): falling edge with L>=GAP_MIN -> MARK, bit index=0. Falling edge with L<GAP_MIN -> error, or repeat handling (see Optional Feature).
  - MARK (low): rising edge -> SPACE if index<16, else -> DONE.
  - SPACE (high): on falling edge, shift (L>BIT_THRESH) into a 16-bit shift register MSB first, index+1, -> MARK. The 17th mark is the stop mark.
  - DONE: code<=shift register this cycle; latch=1 the next cycle; -> IDLE.
- Timeout: in LEADER, GAP, MARK or SPACE, when cnt reaches TIMEOUT with no edge -> frame_err pulse, -> IDLE. code is unchanged.
- Error abort also pulses frame_err for one cycle and returns to IDLE. The shift register is discarded; code is untouched.
- Simultaneous events:
  - A timeout and an edge in the same cycle: the edge wins.
  - A falling edge in the latch cycle is captured by IDLE normally, so back-to-back frames are supported.
- Reset mid-frame: all state is cleared immediately; no latch or frame_err is generated.
- latch and frame_err are never high in the same cycle. Neither is asserted while rst_n=0.

Optional Feature:
- Macro: IR_REPEAT_EN.
- When defined:
  - In GAP, a falling edge with GAP_MIN/4 <= L < GAP_MIN enters the repeat path.
  - The repeat path waits for the rising edge of one mark, then pulses latch with code unchanged.
  - repeat_flag is high in that same cycle only. A repeat arriving before any valid frame still pulses latch with 16'h0000.
- When undefined: every GAP with L<GAP_MIN is an error; repeat_flag is constant 0.

Test Plan:
- Test parameters for all scenarios: LEADER_MIN=8, GAP_MIN=4, BIT_THRESH=3, TIMEOUT=32.
- Valid frame: leader 10 low, gap 6 high, then 16 bits 0x0A0B, each a mark of 2 with space 5 (1) or 2 (0), plus a stop mark of 2. Required: code=16'h0A0B, latch pulses exactly once, one cycle after code changes; frame_err stays 0.
- Leader glitch: ir_rx_n low 5 cycles, then high. Required: busy returns 0, no latch, no frame_err, code unchanged.
- Timeout: valid leader and gap, 3 bits, then hold high 40 cycles. Required: one frame_err pulse when cnt hits 32, FSM in IDLE, code still 16'h0A0B.
- Reset mid-frame: deassert rst_n during the 8th bit space, then release and send frame 0x0A12. Required: outputs at reset values during reset, then code=16'h0A12 with a single latch.
- Repeat (IR_REPEAT_EN defined): after frame 0x0A04, send leader 10, gap 2, mark 2. Required: latch plus repeat_flag for one cycle, code=16'h0A04. With the macro undefined, the same stimulus gives frame_err=1 and no latch.
- Back-to-back: frame 0x0A06 with the next leader falling 1 cycle after the stop mark rises, then frame 0x0A08. Required: two latch pulses, code 0x0A06 then 0x0A08.
